// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage of the riscv32i multicycle core.
// On fetch_start it samples the PC and runs one req/gnt/rvalid read to
// instruction memory. The returned word goes into the instruction register,
// and the fetch PC goes into old_pc_out. Completion or an exception is
// reported back to control as a one-cycle pulse.
// Optional feature: define FETCH_TIMEOUT_EN to bound the number of WAIT
// cycles. When the bound is hit, the fetch faults with an access-fault cause.
module instr_fetch_unit #(
`ifdef FETCH_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
    parameter logic [31:0] RESET_PC  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] ir_out,
    output logic [31:0] old_pc_out,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        exc_valid,
    output logic [3:0]  exc_cause
);

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ACCESS     = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] fetch_pc_r;
    logic [3:0]  cause_s;
    logic [31:0] fault_pc_s;
    logic        latch_pc_s;
    logic        load_ir_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_s;

    // The last WAIT cycle before the limit expires.
    // An rvalid that arrives in this same cycle still completes normally.
    assign timeout_s = (wait_cnt_r == WAIT_LIMIT);

    // Count WAIT cycles. The counter restarts on every REQ->WAIT transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Next-state and transition-event decode.
    // All outputs derived from it are registered below.
    always_comb begin
        state_s    = state_r;
        cause_s    = CAUSE_MISALIGNED;
        fault_pc_s = fetch_pc_r;
        latch_pc_s = 1'b0;
        load_ir_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                fault_pc_s = pc_in;
                if (fetch_start && (pc_in[1:0] == 2'b00)) begin
                    state_s    = ST_REQ;
                    latch_pc_s = 1'b1;
                end else if (fetch_start) begin
                    state_s = ST_FAULT;
                    cause_s = CAUSE_MISALIGNED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid && imem_err) begin
                    state_s = ST_FAULT;
                    cause_s = CAUSE_ACCESS;
                end else if (imem_rvalid && (imem_rdata[1:0] != 2'b11)) begin
                    state_s = ST_FAULT;
                    cause_s = CAUSE_ILLEGAL;
                end else if (imem_rvalid) begin
                    state_s   = ST_DONE;
                    load_ir_s = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_s = ST_FAULT;
                    cause_s = CAUSE_ACCESS;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_FAULT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, registered handshake/status outputs, and the
    // IR/PC capture. The IR and PC values hold between fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= 32'h0000_0000;
            ir_out     <= NOP_INSTR;
            old_pc_out <= RESET_PC;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'd0;
        end else begin
            state_r    <= state_s;
            imem_req   <= (state_s == ST_REQ);
            fetch_busy <= (state_s != ST_IDLE);
            fetch_done <= (state_s == ST_DONE);
            exc_valid  <= (state_s == ST_FAULT);
            if (latch_pc_s) begin
                fetch_pc_r <= pc_in;
                imem_addr  <= {pc_in[31:2], 2'b00};
            end
            if (state_s == ST_FAULT) begin
                exc_cause  <= cause_s;
                old_pc_out <= fault_pc_s;
            end
            if (load_ir_s) begin
                ir_out     <= imem_rdata;
                old_pc_out <= fetch_pc_r;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit.
// Uses a vector table of fetch scenarios with a reactive memory model.
// Each fetch_start pushes an expectation onto a scoreboard queue. The entry
// is popped and compared when fetch_done or exc_valid appears.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] ir_out;
    logic [31:0] old_pc_out;
    logic        fetch_busy;
    logic        fetch_done;
    logic        exc_valid;
    logic [3:0]  exc_cause;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .ir_out      (ir_out),
        .old_pc_out  (old_pc_out),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          gnt_dly;   // REQ cycles without gnt before gnt
        int          rv_dly;    // cycles from gnt to rvalid (>= 1)
        logic        err;
        logic [31:0] rdata;
        logic        noise;     // pulse fetch_start while busy
        logic        exp_exc;
        logic [3:0]  exp_cause;
        logic [31:0] exp_ir;
        logic [31:0] exp_old;
    } vec_t;

    typedef struct {
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] ir;
        logic [31:0] old;
        int          lat;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_start = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'h0000_0000;
    endtask

    // One fetch: drive fetch_start, play memory, and check against the scoreboard.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          nreq;
        int          since_gnt;
        bit          granted;
        bit          finished;
        logic [31:0] ir_prev;
        logic [31:0] old_prev;
        @(negedge clk);
        ir_prev     = ir_out;
        old_prev    = old_pc_out;
        pc_in       = v.pc;
        fetch_start = 1'b1;
        e.exc   = v.exp_exc;
        e.cause = v.exp_cause;
        e.ir    = v.exp_ir;
        e.old   = v.exp_old;
        e.lat   = (v.pc[1:0] != 2'b00) ? 1 : (v.gnt_dly + 2 + v.rv_dly);
        sb.push_back(e);
        cyc = 0; nreq = 0; since_gnt = 0; granted = 0; finished = 0;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            idle_inputs();
            if (v.noise && cyc == 2) begin
                fetch_start = 1'b1;
                pc_in       = 32'h0000_0800;
            end
            if (cyc == 1) chk($sformatf("v%0d busy", idx), 32'(fetch_busy), 32'd1);
            if (fetch_done && exc_valid) chk($sformatf("v%0d done&exc", idx), 32'd1, 32'd0);
            if (granted) begin
                since_gnt++;
                if (since_gnt == v.rv_dly) begin
                    imem_rvalid = 1'b1;
                    imem_err    = v.err;
                    imem_rdata  = v.rdata;
                end
            end
            if (imem_req) begin
                nreq++;
                chk($sformatf("v%0d addr", idx), imem_addr, v.pc);
                if (nreq == v.gnt_dly + 1) begin
                    imem_gnt  = 1'b1;
                    granted   = 1;
                    since_gnt = 0;
                end
            end
            if (fetch_done || exc_valid) begin
                finished = 1;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected completion", idx), 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d exc", idx), 32'(exc_valid), 32'(got.exc));
                    if (got.exc) chk($sformatf("v%0d cause", idx), 32'(exc_cause), 32'(got.cause));
                    chk($sformatf("v%0d ir", idx), ir_out, got.ir);
                    chk($sformatf("v%0d old_pc", idx), old_pc_out, got.old);
                    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(got.lat));
                end
            end else begin
                chk($sformatf("v%0d ir hold", idx), ir_out, ir_prev);
                chk($sformatf("v%0d old hold", idx), old_pc_out, old_prev);
            end
        end
        if (!finished) chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d req count", idx), 32'(nreq),
            (v.pc[1:0] != 2'b00) ? 32'd0 : 32'(v.gnt_dly + 1));
        idle_inputs();
        // Completion pulses must last a single cycle, then the unit is idle.
        @(negedge clk);
        chk($sformatf("v%0d done pulse", idx), 32'(fetch_done), 32'd0);
        chk($sformatf("v%0d exc pulse", idx), 32'(exc_valid), 32'd0);
        chk($sformatf("v%0d idle", idx), 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        //            pc            gd rd err rdata          nz exc cause ir             old
        vecs[0] = '{32'h0000_0100, 0, 1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'd0, 32'h0050_0093, 32'h0000_0100};
        vecs[1] = '{32'h0000_0104, 4, 3, 1'b0, 32'h00A0_0113, 1'b1, 1'b0, 4'd0, 32'h00A0_0113, 32'h0000_0104};
        vecs[2] = '{32'h0000_0102, 0, 1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 4'd0, 32'h00A0_0113, 32'h0000_0102};
        vecs[3] = '{32'h0000_0200, 0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'd1, 32'h00A0_0113, 32'h0000_0200};
        vecs[4] = '{32'h0000_0204, 1, 2, 1'b0, 32'h0000_4501, 1'b1, 1'b1, 4'd2, 32'h00A0_0113, 32'h0000_0204};
        vecs[5] = '{32'h0000_0208, 2, 1, 1'b0, 32'h0020_81B3, 1'b0, 1'b0, 4'd0, 32'h0020_81B3, 32'h0000_0208};
        vecs[6] = '{32'h0000_0103, 0, 1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 4'd0, 32'h0020_81B3, 32'h0000_0103};
        vecs[7] = '{32'h0000_020C, 0, 5, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'h0000_020C};
        vecs[8] = '{32'h0000_0100, 0, 1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'd0, 32'h0050_0093, 32'h0000_0100};

        rst   = 1'b1;
        pc_in = 32'h0000_0000;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", imem_addr, 32'h0000_0000);
        chk("rst ir_out", ir_out, 32'h0000_0013);
        chk("rst old_pc", old_pc_out, 32'h0000_0100);
        chk("rst busy", 32'(fetch_busy), 32'd0);
        chk("rst done", 32'(fetch_done), 32'd0);
        chk("rst exc", 32'(exc_valid), 32'd0);
        chk("rst cause", 32'(exc_cause), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during WAIT, followed by a stray rvalid while IDLE.
        @(negedge clk);
        pc_in       = 32'h0000_0300;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        chk("rw req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("rw wait busy", 32'(fetch_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw ir reset", ir_out, 32'h0000_0013);
        chk("rw old reset", old_pc_out, 32'h0000_0100);
        chk("rw busy reset", 32'(fetch_busy), 32'd0);
        chk("rw addr reset", imem_addr, 32'h0000_0000);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5693;
        @(negedge clk);
        idle_inputs();
        chk("stray ir", ir_out, 32'h0000_0013);
        chk("stray done", 32'(fetch_done), 32'd0);
        chk("stray busy", 32'(fetch_busy), 32'd0);
        @(negedge clk);
        chk("stray done2", 32'(fetch_done), 32'd0);
        chk("stray exc2", 32'(exc_valid), 32'd0);

        run_vec(vecs[8], 8);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
